// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with a transmit sequencer that feeds uart_tx one frame at a time
module uart_tx_fifo #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              timeout_err,
    output logic              busy,
    output logic [DATA_W-1:0] tx_data_in,
    output logic              tx_data_en,
    input  logic              tx_finish
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    state_t             state_q,     state_d;
    logic [ADDR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [ADDR_W:0]    count_q,     count_d;
    logic               full_q,      full_d;
    logic               empty_q,     empty_d;
    logic               overflow_q,  overflow_d;
    logic               timeout_q,   timeout_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic               en_q,        en_d;

    logic               do_push;
    logic               do_pop;

    // Pushes are gated by the registered full flag, so a pop in the same
    // cycle never rescues a push that arrives while full.
    always_comb begin
        do_push    = wr_en & ~full_q;
        do_pop     = (state_q == S_IDLE) & ~empty_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & full_q);

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        en_d      = 1'b0;
        timer_d   = timer_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (do_pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                en_d    = 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tx_finish wins over a timeout landing in the same cycle.
                if (tx_finish) begin
                    state_d = S_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            timer_q    <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            en_q       <= en_d;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE);
    assign tx_data_in  = data_q;
    assign tx_data_en  = en_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk_in;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              timeout_err;
    logic              busy;
    logic [DATA_W-1:0] tx_data_in;
    logic              tx_data_en;
    logic              tx_finish;

    int checks;
    int failures;
    int cyc;
    int en_double;
    logic prev_en;
    int model_on;
    int model_delay;
    int model_rand;

    logic [DATA_W-1:0] sent_q[$];
    int                sent_cyc[$];
    logic [DATA_W-1:0] exp_q[$];

    uart_tx_fifo #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .busy        (busy),
        .tx_data_in  (tx_data_in),
        .tx_data_en  (tx_data_en),
        .tx_finish   (tx_finish)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        cyc       = 0;
        en_double = 0;
        prev_en   = 1'b0;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (tx_data_en) begin
            sent_q.push_back(tx_data_in);
            sent_cyc.push_back(cyc);
            if (prev_en) en_double <= en_double + 1;
        end
        prev_en <= tx_data_en;
    end

    // uart_tx model: answers each start pulse with tx_finish d cycles later
    initial begin
        int d;
        tx_finish = 1'b0;
        forever begin
            @(negedge clk_in);
            if (tx_data_en && (model_on != 0)) begin
                d = (model_rand != 0) ? int'($urandom_range(30, 1)) : model_delay;
                repeat (d - 1) @(negedge clk_in);
                tx_finish = 1'b1;
                @(negedge clk_in);
                tx_finish = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic [DATA_W-1:0] b;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        model_on    = 0;
        model_delay = 20;
        model_rand  = 0;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(tx_data_in), 0);
        check("rst_en", 32'(tx_data_en), 0);
        tick();

        // single byte latency
        model_on = 1;
        model_delay = 20;
        sent_q.delete();
        sent_cyc.delete();
        wr_data = 8'hA5;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("t2_count_e", 32'(count), 1);
        check("t2_empty_e", 32'(empty), 0);
        tick();
        check("t2_data_e1", 32'(tx_data_in), 32'hA5);
        check("t2_busy_e1", 32'(busy), 1);
        check("t2_count_e1", 32'(count), 0);
        check("t2_en_e1", 32'(tx_data_en), 0);
        tick();
        check("t2_en_e2", 32'(tx_data_en), 1);
        tick();
        check("t2_en_e3", 32'(tx_data_en), 0);
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("t2_busy_len", 32'(n), 19);
        check("t2_empty_end", 32'(empty), 1);
        check("t2_sent_n", 32'(sent_q.size()), 1);
        check("t2_sent_0", 32'(sent_q[0]), 32'hA5);

        // back-to-back burst
        sent_q.delete();
        sent_cyc.delete();
        wr_en = 1'b1;
        wr_data = 8'h01; tick();
        wr_data = 8'h02; tick();
        wr_data = 8'h03; tick();
        wr_en = 1'b0;
        n = 0;
        while ((sent_q.size() < 3 || busy) && n < 500) begin tick(); n++; end
        check("t3_sent_n", 32'(sent_q.size()), 3);
        for (int i = 0; i < 3; i++) check("t3_byte", 32'(sent_q[i]), 32'(i + 1));
        check("t3_gap1", 32'(sent_cyc[1] - sent_cyc[0]), 22);
        check("t3_gap2", 32'(sent_cyc[2] - sent_cyc[1]), 22);
        check("t3_empty", 32'(empty), 1);

        // fill beyond capacity while the first frame is outstanding
        sent_q.delete();
        model_delay = 30;
        wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t4_count", 32'(count), 16);
        check("t4_full", 32'(full), 1);
        check("t4_overflow", 32'(overflow), 1);
        check("t4_busy", 32'(busy), 1);
        check("t4_inflight", 32'(tx_data_in), 0);
        n = 0;
        while ((sent_q.size() < 17 || busy) && n < 2000) begin tick(); n++; end
        check("t4_sent_n", 32'(sent_q.size()), 17);
        for (int i = 0; i < 17; i++) check("t4_byte", 32'(sent_q[i]), 32'(i));
        check("t4_count_end", 32'(count), 0);
        check("t4_full_end", 32'(full), 0);
        check("t4_overflow_end", 32'(overflow), 1);

        // reset in the middle of a frame
        sent_q.delete();
        model_on = 0;
        wr_en = 1'b1;
        wr_data = 8'h3C; tick();
        wr_data = 8'h4D; tick();
        wr_en = 1'b0;
        tick();
        tick();
        check("t1_busy_pre", 32'(busy), 1);
        check("t1_count_pre", 32'(count), 1);
        check("t1_data_pre", 32'(tx_data_in), 32'h3C);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("t1_count", 32'(count), 0);
        check("t1_empty", 32'(empty), 1);
        check("t1_full", 32'(full), 0);
        check("t1_overflow", 32'(overflow), 0);
        check("t1_timeout", 32'(timeout_err), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_data", 32'(tx_data_in), 0);
        check("t1_en", 32'(tx_data_en), 0);
        repeat (60) tick();
        check("t1_no_pulse", 32'(sent_q.size()), 1);
        check("t1_idle", 32'(busy), 0);
        check("t1_empty_late", 32'(empty), 1);

        // random traffic with pointer wrap
        sent_q.delete();
        exp_q.delete();
        model_on = 1;
        model_rand = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(25, 0)) tick();
            n = 0;
            while (full && n < 2000) begin tick(); n++; end
            b = 8'($urandom_range(255, 0));
            exp_q.push_back(b);
            wr_data = b;
            wr_en = 1'b1;
            tick();
            wr_en = 1'b0;
        end
        n = 0;
        while ((sent_q.size() < 40 || busy) && n < 5000) begin tick(); n++; end
        check("t5_sent_n", 32'(sent_q.size()), 40);
        for (int i = 0; i < 40; i++) check("t5_byte", 32'(sent_q[i]), 32'(exp_q[i]));
        check("t5_overflow", 32'(overflow), 0);
        check("t5_timeout", 32'(timeout_err), 0);

        // WAIT timeout, then normal recovery
        sent_q.delete();
        model_on = 0;
        model_rand = 0;
        wr_data = 8'h77;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        check("t6_en", 32'(tx_data_en), 1);
        check("t6_timeout_pre", 32'(timeout_err), 0);
        tick();
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("t6_wait_len", 32'(n), 49);
        check("t6_timeout", 32'(timeout_err), 1);
        model_on = 1;
        model_delay = 10;
        wr_data = 8'h88;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n = 0;
        while ((sent_q.size() < 2 || busy) && n < 200) begin tick(); n++; end
        check("t6_sent_n", 32'(sent_q.size()), 2);
        check("t6_next_byte", 32'(sent_q[1]), 32'h88);
        check("t6_timeout_sticky", 32'(timeout_err), 1);
        check("t6_empty", 32'(empty), 1);

        check("en_single_cycle", 32'(en_double), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
